// File: rtl/predictor_mvmult_sched_pkg.sv
// Shared types and constants for the predictor K*x scheduler.
//  - data widths, multiplier depth and fixed-point shift
//  - scheduler FSM state encoding
//  - in-flight tag that travels alongside each multiplier product
//  - helpers: index width of a count, Q32 scaling of a raw product
package predictor_mvmult_sched_pkg;

    localparam int COEF_W    = 29;
    localparam int X_W       = 64;
    localparam int FRAC_SH   = 32;
    localparam int MUL_LAT   = 5;
    localparam int PROD_W    = 92;
    // Rows representable in a tag; supports up to 16 rows of K.
    localparam int TAG_ROW_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_ROW_W-1:0] row;
        logic                 last;
    } sched_tag_t;

    // Index width for a count, never below 1 bit so a single entry still has an address.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Arithmetic shift right by FRAC_SH (floor), sign-extended to X_W.
    function automatic logic [X_W-1:0] scale_prod(input logic [PROD_W-1:0] p);
        return {{(X_W - (PROD_W - FRAC_SH)){p[PROD_W-1]}}, p[PROD_W-1:FRAC_SH]};
    endfunction

endpackage

// File: rtl/predictor_mvmult_sched_if.sv
// Bus between the predictor top FSM (master) and the K*x scheduler (slave).
//  ap_start  master->slave  start request, looked at only while the scheduler is idle
//  ap_ready  slave->master  pulse: last product issued, x_in may change from next cycle
//  ap_done   slave->master  pulse: every y_out row is final
//  ap_idle   slave->master  scheduler idle with nothing in flight
//  x_in      master->slave  vector, element c at [c*X_W +: X_W]
//  coef_addr slave->master  row-major ROM index r*N_COLS+c
//  coef_data master->slave  signed ROM word, combinational from coef_addr
//  y_out     slave->master  results, row r at [r*X_W +: X_W]
//  y_vld     slave->master  per-row pulse the cycle after row r becomes final
// Handshake: a run begins on the first clock edge where ap_start is high while
// ap_idle is high; ap_start is ignored at all other times. ap_ready and ap_done
// are single-cycle pulses with no back-pressure; the master must accept them.
interface predictor_mvmult_sched_if
    import predictor_mvmult_sched_pkg::*;
#(
    parameter int N_ROWS = 2,
    parameter int N_COLS = 2
);
    localparam int ADDR_W = idx_w(N_ROWS * N_COLS);

    logic                     ap_start;
    logic                     ap_ready;
    logic                     ap_done;
    logic                     ap_idle;
    logic [N_COLS*X_W-1:0]    x_in;
    logic [ADDR_W-1:0]        coef_addr;
    logic [COEF_W-1:0]        coef_data;
    logic [N_ROWS*X_W-1:0]    y_out;
    logic [N_ROWS-1:0]        y_vld;

    modport master (
        output ap_start, x_in, coef_data,
        input  ap_ready, ap_done, ap_idle, coef_addr, y_out, y_vld
    );

    modport slave (
        input  ap_start, x_in, coef_data,
        output ap_ready, ap_done, ap_idle, coef_addr, y_out, y_vld
    );

endinterface

// File: rtl/predictor_mvmult_sched_mul_pipe.sv
// Pipelined signed multiplier, MUL_LAT register stages from inputs to output.
//  ap_clk, ap_rst  clock / asynchronous active-high reset
//  i_a             signed COEF_W coefficient
//  i_b             signed X_W vector element
//  o_p             signed product, low PROD_W bits, MUL_LAT cycles after i_a/i_b
module predictor_mvmult_sched_mul_pipe
    import predictor_mvmult_sched_pkg::*;
(
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [COEF_W-1:0] i_a,
    input  logic [X_W-1:0]    i_b,
    output logic [PROD_W-1:0] o_p
);
    logic [COEF_W-1:0] r_a;
    logic [X_W-1:0]    r_b;
    logic [PROD_W-1:0] r_p [MUL_LAT-1];
    logic [PROD_W-1:0] w_a_ext;
    logic [PROD_W-1:0] w_b_ext;
    logic [PROD_W-1:0] w_prod;

    // Both operands sign-extended to the product width: the low PROD_W bits of a
    // modular multiply equal the signed product's low bits.
    assign w_a_ext = {{(PROD_W - COEF_W){r_a[COEF_W-1]}}, r_a};
    assign w_b_ext = {{(PROD_W - X_W){r_b[X_W-1]}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;
    assign o_p     = r_p[MUL_LAT-2];

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_a <= '0;
            r_b <= '0;
            for (int s = 0; s < MUL_LAT - 1; s++) r_p[s] <= '0;
        end else begin
            r_a    <= i_a;
            r_b    <= i_b;
            r_p[0] <= w_prod;
            for (int s = 1; s < MUL_LAT - 1; s++) r_p[s] <= r_p[s-1];
        end
    end

endmodule

// File: rtl/predictor_mvmult_sched.sv
// Sequencer for y = K*x using one shared pipelined multiplier.
//  ap_clk, ap_rst  clock / asynchronous active-high reset
//  bus             slave side of predictor_mvmult_sched_if (start/ready/done/idle,
//                  x_in, coefficient ROM port, y_out, y_vld)
//  o_dbg_state     current scheduler FSM state
// One row/col product is issued per cycle in row-major order; a tag riding in a
// shift register beside the multiplier says which row accumulator the product
// lands in and whether it closes that row.
module predictor_mvmult_sched
    import predictor_mvmult_sched_pkg::*;
#(
    parameter int N_ROWS = 2,
    parameter int N_COLS = 2
)(
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    predictor_mvmult_sched_if.slave  bus,
    output sched_state_t             o_dbg_state
);
    localparam int N      = N_ROWS * N_COLS;
    localparam int ADDR_W = idx_w(N);
    localparam int ROW_W  = idx_w(N_ROWS);
    localparam int COL_W  = idx_w(N_COLS);

    sched_state_t      r_state, w_next;
    logic [ADDR_W-1:0] r_k;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic [X_W-1:0]    r_x   [N_COLS];
    logic [X_W-1:0]    r_acc [N_ROWS];
    logic [X_W-1:0]    r_y   [N_ROWS];
    logic [N_ROWS-1:0] r_vld;
    sched_tag_t        r_tag [MUL_LAT];

    logic              w_issue, w_last_issue, w_final, w_inflight, w_start;
    sched_tag_t        w_tag_in, w_tag_out;
    logic [X_W-1:0]    w_xsel, w_acc_sel, w_sum;
    logic [PROD_W-1:0] w_prod;

    predictor_mvmult_sched_mul_pipe u_mul (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .i_a    (bus.coef_data),
        .i_b    (w_xsel),
        .o_p    (w_prod)
    );

    // FSM state register
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // FSM next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.ap_start) w_next = ST_ISSUE;
            ST_ISSUE: if (w_last_issue) w_next = ST_DRAIN;
            ST_DRAIN: if (w_final)      w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.ap_ready  = w_last_issue;
        bus.ap_done   = (r_state == ST_DONE);
        bus.ap_idle   = (r_state == ST_IDLE) && !w_inflight;
        bus.coef_addr = w_issue ? r_k : '0;
        bus.y_vld     = r_vld;
        bus.y_out     = '0;
        for (int r = 0; r < N_ROWS; r++) bus.y_out[r*X_W +: X_W] = r_y[r];
        o_dbg_state   = r_state;
    end

    // Issue-side selects and output-side decode of the tag pipe
    always_comb begin
        w_start        = (r_state == ST_IDLE) && bus.ap_start;
        w_issue        = (r_state == ST_ISSUE);
        w_last_issue   = w_issue && (r_k == ADDR_W'(N - 1));
        w_xsel         = '0;
        for (int c = 0; c < N_COLS; c++)
            if (r_col == COL_W'(c)) w_xsel = r_x[c];
        w_tag_in.valid = w_issue;
        w_tag_in.row   = TAG_ROW_W'(r_row);
        w_tag_in.last  = (r_col == COL_W'(N_COLS - 1));
        w_tag_out      = r_tag[MUL_LAT-1];
        // Rows are issued in order, so the closing tag of the last row is the last in flight.
        w_final        = w_tag_out.valid && w_tag_out.last &&
                         (w_tag_out.row == TAG_ROW_W'(N_ROWS - 1));
        w_inflight     = 1'b0;
        for (int t = 0; t < MUL_LAT; t++) w_inflight = w_inflight | r_tag[t].valid;
        w_acc_sel      = '0;
        for (int r = 0; r < N_ROWS; r++)
            if (w_tag_out.row == TAG_ROW_W'(r)) w_acc_sel = r_acc[r];
        w_sum          = w_acc_sel + scale_prod(w_prod);
    end

    // Counters, captured vector, tag pipe, accumulators and results
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_k   <= '0;
            r_row <= '0;
            r_col <= '0;
            r_vld <= '0;
            for (int c = 0; c < N_COLS; c++) r_x[c] <= '0;
            for (int r = 0; r < N_ROWS; r++) begin
                r_acc[r] <= '0;
                r_y[r]   <= '0;
            end
            for (int t = 0; t < MUL_LAT; t++) r_tag[t] <= '0;
        end else begin
            r_tag[0] <= w_tag_in;
            for (int t = 1; t < MUL_LAT; t++) r_tag[t] <= r_tag[t-1];

            r_vld <= '0;
            if (w_tag_out.valid) begin
                for (int r = 0; r < N_ROWS; r++) begin
                    if (w_tag_out.row == TAG_ROW_W'(r)) begin
                        r_acc[r] <= w_sum;
                        if (w_tag_out.last) begin
                            r_y[r]   <= w_sum;
                            r_vld[r] <= 1'b1;
                        end
                    end
                end
            end

            if (w_start) begin
                for (int c = 0; c < N_COLS; c++) r_x[c] <= bus.x_in[c*X_W +: X_W];
                for (int r = 0; r < N_ROWS; r++) r_acc[r] <= '0;
                r_k   <= '0;
                r_row <= '0;
                r_col <= '0;
            end else if (w_issue) begin
                r_k <= r_k + 1'b1;
                if (r_col == COL_W'(N_COLS - 1)) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_predictor_mvmult_sched.sv
// Bench for predictor_mvmult_sched: four instances (2x1, 2x2, 1x1, 2x4) share one
// coefficient table and one vector table; each run drives a single instance.
module tb_predictor_mvmult_sched;
    import predictor_mvmult_sched_pkg::*;

    typedef struct packed {
        int              d;
        int              lat;
        int              nrows;
        logic [7:0][28:0] c;
        logic [3:0][63:0] x;
        logic [1:0][63:0] e;
    } vec_t;

    logic             ap_clk;
    logic             ap_rst;
    logic [3:0]       st;
    logic [63:0]      xv   [4];
    logic [28:0]      rom  [8];
    logic             done_v  [4];
    logic             ready_v [4];
    logic             idle_v  [4];
    logic [1:0]       vld_v   [4];
    logic [63:0]      yv   [4][2];
    sched_state_t     dbg  [4];
    vec_t             vt   [6];
    logic [63:0]      exp_q[$];
    int               n_chk;
    int               n_err;

    // ---------------- instances ----------------
    predictor_mvmult_sched_if #(.N_ROWS(2), .N_COLS(1)) if0 ();
    predictor_mvmult_sched_if #(.N_ROWS(2), .N_COLS(2)) if1 ();
    predictor_mvmult_sched_if #(.N_ROWS(1), .N_COLS(1)) if2 ();
    predictor_mvmult_sched_if #(.N_ROWS(2), .N_COLS(4)) if3 ();

    predictor_mvmult_sched #(.N_ROWS(2), .N_COLS(1)) dut0 (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(if0.slave), .o_dbg_state(dbg[0]));
    predictor_mvmult_sched #(.N_ROWS(2), .N_COLS(2)) dut1 (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(if1.slave), .o_dbg_state(dbg[1]));
    predictor_mvmult_sched #(.N_ROWS(1), .N_COLS(1)) dut2 (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(if2.slave), .o_dbg_state(dbg[2]));
    predictor_mvmult_sched #(.N_ROWS(2), .N_COLS(4)) dut3 (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(if3.slave), .o_dbg_state(dbg[3]));

    assign if0.ap_start  = st[0];
    assign if0.x_in      = xv[0];
    assign if0.coef_data = rom[{2'b00, if0.coef_addr}];
    assign if1.ap_start  = st[1];
    assign if1.x_in      = {xv[1], xv[0]};
    assign if1.coef_data = rom[{1'b0, if1.coef_addr}];
    assign if2.ap_start  = st[2];
    assign if2.x_in      = xv[0];
    assign if2.coef_data = rom[{2'b00, if2.coef_addr}];
    assign if3.ap_start  = st[3];
    assign if3.x_in      = {xv[3], xv[2], xv[1], xv[0]};
    assign if3.coef_data = rom[if3.coef_addr];

    assign done_v[0] = if0.ap_done;  assign ready_v[0] = if0.ap_ready;  assign idle_v[0] = if0.ap_idle;
    assign done_v[1] = if1.ap_done;  assign ready_v[1] = if1.ap_ready;  assign idle_v[1] = if1.ap_idle;
    assign done_v[2] = if2.ap_done;  assign ready_v[2] = if2.ap_ready;  assign idle_v[2] = if2.ap_idle;
    assign done_v[3] = if3.ap_done;  assign ready_v[3] = if3.ap_ready;  assign idle_v[3] = if3.ap_idle;
    assign vld_v[0] = if0.y_vld;
    assign vld_v[1] = if1.y_vld;
    assign vld_v[2] = {1'b0, if2.y_vld};
    assign vld_v[3] = if3.y_vld;
    assign yv[0][0] = if0.y_out[63:0];  assign yv[0][1] = if0.y_out[127:64];
    assign yv[1][0] = if1.y_out[63:0];  assign yv[1][1] = if1.y_out[127:64];
    assign yv[2][0] = if2.y_out;        assign yv[2][1] = '0;
    assign yv[3][0] = if3.y_out[63:0];  assign yv[3][1] = if3.y_out[127:64];

    // ---------------- clock / reset ----------------
    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic load_vec(input int i);
        for (int k = 0; k < 8; k++) rom[k] = vt[i].c[k];
        for (int k = 0; k < 4; k++) xv[k] = vt[i].x[k];
    endtask

    // ---------------- driver: one full run of a table entry ----------------
    task automatic run_vec(input int i);
        int d, cnt, n, ncols, rdy_at, rdy_n;
        int v_at[2];
        int v_n[2];
        d = vt[i].d;
        n = vt[i].lat - MUL_LAT - 1;
        ncols = n / vt[i].nrows;
        load_vec(i);
        for (int r = 0; r < vt[i].nrows; r++) exp_q.push_back(vt[i].e[r]);
        rdy_at = -1; rdy_n = 0;
        v_at[0] = -1; v_at[1] = -1; v_n[0] = 0; v_n[1] = 0;
        st[d] = 1'b1;
        cnt = 0;
        while (cnt < 60) begin
            @(negedge ap_clk);
            cnt++;
            st[d] = 1'b0;
            if (ready_v[d]) begin
                if (rdy_at < 0) rdy_at = cnt;
                rdy_n++;
            end
            for (int r = 0; r < 2; r++)
                if (vld_v[d][r]) begin
                    if (v_at[r] < 0) v_at[r] = cnt;
                    v_n[r]++;
                end
            if (done_v[d]) break;
        end
        chk($sformatf("v%0d latency", i), 64'(cnt), 64'(vt[i].lat));
        chk($sformatf("v%0d ready_cycle", i), 64'(rdy_at), 64'(n));
        chk($sformatf("v%0d ready_count", i), 64'(rdy_n), 64'd1);
        for (int r = 0; r < vt[i].nrows; r++) begin
            chk($sformatf("v%0d y%0d", i, r), yv[d][r], exp_q.pop_front());
            chk($sformatf("v%0d vld%0d_count", i, r), 64'(v_n[r]), 64'd1);
            chk($sformatf("v%0d vld%0d_cycle", i, r), 64'(v_at[r]), 64'((r + 1) * ncols + MUL_LAT + 1));
        end
        @(negedge ap_clk);
        chk($sformatf("v%0d idle_after", i), 64'(idle_v[d]), 64'd1);
        chk($sformatf("v%0d done_after", i), 64'(done_v[d]), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt, dn, done_at, ev;
        n_chk = 0;
        n_err = 0;
        ap_rst = 1'b1;
        st = '0;
        for (int k = 0; k < 4; k++) xv[k] = '0;
        for (int k = 0; k < 8; k++) rom[k] = '0;

        for (int i = 0; i < 6; i++) vt[i] = '0;
        // 2x1: Q32 identity on x0
        vt[0].d = 0; vt[0].nrows = 2; vt[0].lat = 8;
        vt[0].c[0] = 29'd190532990; vt[0].c[1] = 29'd95724;
        vt[0].x[0] = 64'h0000_0001_0000_0000;
        vt[0].e[0] = 64'd190532990; vt[0].e[1] = 64'd95724;
        // 2x2: 1-2 = -1, 3-4 = -1
        vt[1].d = 1; vt[1].nrows = 2; vt[1].lat = 10;
        vt[1].c[0] = 29'd1; vt[1].c[1] = 29'd2; vt[1].c[2] = 29'd3; vt[1].c[3] = 29'd4;
        vt[1].x[0] = 64'h0000_0001_0000_0000; vt[1].x[1] = 64'hFFFF_FFFF_0000_0000;
        vt[1].e[0] = 64'hFFFF_FFFF_FFFF_FFFF; vt[1].e[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        // 1x1: -1 * 1 -> floor(-1/2^32) = -1
        vt[2].d = 2; vt[2].nrows = 1; vt[2].lat = 7;
        vt[2].c[0] = 29'h1FFF_FFFF;
        vt[2].x[0] = 64'd1;
        vt[2].e[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        // 2x4: extreme coefficients against max positive x
        vt[3].d = 3; vt[3].nrows = 2; vt[3].lat = 14;
        for (int k = 0; k < 4; k++) begin
            vt[3].c[k]     = 29'h0FFF_FFFF;
            vt[3].c[k + 4] = 29'h1000_0000;
            vt[3].x[k]     = 64'h7FFF_FFFF_FFFF_FFFF;
        end
        vt[3].e[0] = 64'h1FFF_FFFD_FFFF_FFFC; vt[3].e[1] = 64'hE000_0000_0000_0000;
        // 2x2: fractional x, floor on negative halves: -5+10=5, 10-22=-12
        vt[4].d = 1; vt[4].nrows = 2; vt[4].lat = 10;
        vt[4].c[0] = -29'sd3; vt[4].c[1] = 29'd5; vt[4].c[2] = 29'd7; vt[4].c[3] = -29'sd11;
        vt[4].x[0] = 64'h0000_0001_8000_0000; vt[4].x[1] = 64'h0000_0002_0000_0000;
        vt[4].e[0] = 64'd5; vt[4].e[1] = 64'hFFFF_FFFF_FFFF_FFF4;
        // 2x1: x = -0.5: 3.5 -> 3, -134217727.5 -> -134217728
        vt[5].d = 0; vt[5].nrows = 2; vt[5].lat = 8;
        vt[5].c[0] = -29'sd7; vt[5].c[1] = 29'h0FFF_FFFF;
        vt[5].x[0] = 64'hFFFF_FFFF_8000_0000;
        vt[5].e[0] = 64'd3; vt[5].e[1] = 64'hFFFF_FFFF_F800_0000;

        // reset state
        repeat (3) @(negedge ap_clk);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("rst idle%0d", d), 64'(idle_v[d]), 64'd1);
            chk($sformatf("rst done%0d", d), 64'(done_v[d]), 64'd0);
            chk($sformatf("rst ready%0d", d), 64'(ready_v[d]), 64'd0);
            chk($sformatf("rst vld%0d", d), 64'(vld_v[d]), 64'd0);
            chk($sformatf("rst y%0d", d), yv[d][0] | yv[d][1], 64'd0);
            chk($sformatf("rst state%0d", d), 64'(dbg[d]), 64'(ST_IDLE));
        end
        ap_rst = 1'b0;
        @(negedge ap_clk);

        // table-driven runs
        for (int i = 0; i < 6; i++) run_vec(i);

        // start held high through the run, x_in disturbed after capture
        load_vec(1);
        exp_q.push_back(vt[1].e[0]);
        exp_q.push_back(vt[1].e[1]);
        st[1] = 1'b1;
        dn = 0; done_at = -1;
        for (cnt = 1; cnt <= 30; cnt++) begin
            @(negedge ap_clk);
            if (cnt == 1) begin
                xv[0] = 64'h1234_5678_9ABC_DEF0;
                xv[1] = 64'h0FED_CBA9_8765_4321;
            end
            if (cnt == 3) begin
                chk("hold y0_prev", yv[1][0], 64'd5);
                chk("hold y1_prev", yv[1][1], 64'hFFFF_FFFF_FFFF_FFF4);
            end
            if (done_v[1]) begin
                dn++;
                if (done_at < 0) done_at = cnt;
                st[1] = 1'b0;
            end
        end
        st[1] = 1'b0;
        chk("hold done_count", 64'(dn), 64'd1);
        chk("hold latency", 64'(done_at), 64'd10);
        chk("hold y0", yv[1][0], exp_q.pop_front());
        chk("hold y1", yv[1][1], exp_q.pop_front());

        // reset while draining
        load_vec(0);
        st[0] = 1'b1;
        repeat (4) begin
            @(negedge ap_clk);
            st[0] = 1'b0;
        end
        chk("rst_mid state_before", 64'(dbg[0]), 64'(ST_DRAIN));
        chk("rst_mid idle_before", 64'(idle_v[0]), 64'd0);
        ap_rst = 1'b1;
        #1;
        chk("rst_mid idle", 64'(idle_v[0]), 64'd1);
        chk("rst_mid done", 64'(done_v[0]), 64'd0);
        chk("rst_mid vld", 64'(vld_v[0]), 64'd0);
        chk("rst_mid y", yv[0][0] | yv[0][1], 64'd0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        ev = 0;
        repeat (12) begin
            @(negedge ap_clk);
            if (done_v[0] || vld_v[0] != 2'b00) ev++;
        end
        chk("rst_mid no_events", 64'(ev), 64'd0);
        run_vec(0);
        run_vec(5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
